// File: rtl/cmp_unit.sv
// rtl/cmp_unit.sv - iterative MSB-first compare unit with early termination
module cmp_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2,
    parameter int RD_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    output logic             busy,
    output logic             done,
    output logic [RD_W-1:0]  rd,
    output logic [2:0]       flags,
    output logic             invalid_op
);
    localparam int N  = WIDTH / DIGIT;
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam logic [GW-1:0] LAST_G = GW'(N - 1);

    localparam logic [4:0] OP_LT  = 5'b01011;
    localparam logic [4:0] OP_GT  = 5'b01100;
    localparam logic [4:0] OP_EQ  = 5'b01101;
    localparam logic [4:0] OP_GTE = 5'b01110;
    localparam logic [4:0] OP_LTE = 5'b01111;
    localparam logic [4:0] OP_NE  = 5'b10000;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  a, b;
    logic [4:0]        op;
    logic              op_ok;
    logic [GW-1:0]     g;
    logic [DIGIT-1:0]  grp_a, grp_b;
    logic              fin, lt_c, gt_c, eq_c, cond;

    // Operands shift left after each equal group, so the active group is always on top.
    assign grp_a = a[WIDTH-1 -: DIGIT];
    assign grp_b = b[WIDTH-1 -: DIGIT];
    assign busy  = (state == RUN);

    always_comb begin
        state_n = state;
        fin     = 1'b0;
        lt_c    = 1'b0;
        gt_c    = 1'b0;
        eq_c    = 1'b0;
        cond    = 1'b0;
        case (state)
            IDLE: if (start) state_n = RUN;
            RUN: begin
                if (op_ok) begin
                    lt_c = (grp_a < grp_b);
                    gt_c = (grp_a > grp_b);
                    eq_c = !lt_c && !gt_c;
                end
                fin = !op_ok || lt_c || gt_c || (g == LAST_G);
                if (fin) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        case (op)
            OP_LT:   cond = lt_c;
            OP_GT:   cond = gt_c;
            OP_EQ:   cond = eq_c;
            OP_GTE:  cond = gt_c || eq_c;
            OP_LTE:  cond = lt_c || eq_c;
            OP_NE:   cond = !eq_c;
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            op         <= '0;
            op_ok      <= 1'b0;
            g          <= '0;
            done       <= 1'b0;
            rd         <= '0;
            flags      <= 3'b000;
            invalid_op <= 1'b0;
        end else begin
            state <= state_n;
            done  <= fin;
            if (state == IDLE && start) begin
                // Flipping the sign bit maps two's complement onto offset binary.
                a     <= {r1[WIDTH-1] ^ signed_mode, r1[WIDTH-2:0]};
                b     <= {r2[WIDTH-1] ^ signed_mode, r2[WIDTH-2:0]};
                op    <= opcode;
                op_ok <= (opcode >= OP_LT) && (opcode <= OP_NE);
                g     <= '0;
            end else if (state == RUN && !fin) begin
                a <= a << DIGIT;
                b <= b << DIGIT;
                g <= g + 1'b1;
            end
            if (fin) begin
                rd         <= RD_W'(cond);
                flags      <= {lt_c, eq_c, gt_c};
                invalid_op <= !op_ok;
            end
        end
    end
endmodule

// File: tb/tb_cmp_unit.sv
// tb/tb_cmp_unit.sv - directed self-checking bench for cmp_unit
module tb_cmp_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] opcode;
    logic       signed_mode;
    logic [7:0] r1, r2;
    logic       busy, done, invalid_op;
    logic [2:0] rd;
    logic [2:0] flags;

    int checks = 0;
    int failures = 0;
    int lat;
    int seen;

    cmp_unit #(.WIDTH(8), .DIGIT(2), .RD_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .signed_mode(signed_mode), .r1(r1), .r2(r2), .busy(busy),
        .done(done), .rd(rd), .flags(flags), .invalid_op(invalid_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] o, input logic sm, input logic [7:0] a, input logic [7:0] b);
        opcode = o; signed_mode = sm; r1 = a; r2 = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic launch(input logic [4:0] o, input logic sm, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        drive(o, sm, a, b);
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [4:0] o, input logic sm,
                       input logic [7:0] a, input logic [7:0] b,
                       input int e_lat, input int e_rd, input int e_fl, input int e_inv);
        int l;
        launch(o, sm, a, b);
        wait_done(l);
        chk({tag, "_lat"}, l, e_lat);
        chk({tag, "_rd"}, rd, e_rd);
        chk({tag, "_flags"}, flags, e_fl);
        chk({tag, "_inv"}, invalid_op, e_inv);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; opcode = '0; signed_mode = 1'b0; r1 = '0; r2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd", rd, 0);
        chk("rst_flags", flags, 0);
        chk("rst_inv", invalid_op, 0);
        @(negedge clk) rst_n = 1'b1;

        launch(5'b01011, 1'b0, 8'h12, 8'h34);
        chk("lt_busy", busy, 1);
        wait_done(lat);
        chk("lt_lat", lat, 2);
        chk("lt_rd", rd, 1);
        chk("lt_flags", flags, 3'b100);
        chk("lt_inv", invalid_op, 0);
        chk("lt_busy_done", busy, 0);

        drive(5'b01011, 1'b0, 8'h00, 8'h80);
        chk("b2b_done_low", done, 0);
        chk("b2b_busy", busy, 1);
        wait_done(lat);
        chk("b2b_lat", lat, 1);
        chk("b2b_rd", rd, 1);
        chk("b2b_flags", flags, 3'b100);

        run("eq",   5'b01101, 1'b0, 8'hA5, 8'hA5, 4, 1, 3'b010, 0);
        run("ne",   5'b10000, 1'b0, 8'hA5, 8'hA5, 4, 0, 3'b010, 0);
        run("gt_s", 5'b01100, 1'b1, 8'h01, 8'hFF, 1, 1, 3'b001, 0);
        run("gt_u", 5'b01100, 1'b0, 8'h01, 8'hFF, 1, 0, 3'b100, 0);
        run("gte_s", 5'b01110, 1'b1, 8'h80, 8'h7F, 1, 0, 3'b100, 0);
        run("inv",  5'b00000, 1'b0, 8'h03, 8'h03, 1, 0, 3'b000, 1);
        run("lte",  5'b01111, 1'b0, 8'h03, 8'h03, 4, 1, 3'b010, 0);

        launch(5'b01101, 1'b0, 8'h55, 8'h55);
        @(negedge clk);
        opcode = 5'b01011; r1 = 8'h00; r2 = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        chk("ign_lat", lat + 1, 4);
        chk("ign_rd", rd, 1);
        chk("ign_flags", flags, 3'b010);

        launch(5'b01101, 1'b0, 8'h55, 8'h55);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_rd", rd, 0);
        chk("arst_flags", flags, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("arst_no_done", seen, 0);
        chk("arst_rd_hold", rd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
